// File: rtl/rf_param.sv
// Parameterised multi-port register file: two combinational read ports, one write port,
// optional hardwired zero register, optional write-to-read forwarding and a sequential clear sweep.
module rf_param #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int AW       = $clog2(DEPTH),
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    rn1,
  input  logic [AW-1:0]    rn2,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  input  logic [AW-1:0]    wn,
  input  logic [WIDTH-1:0] wd,
  input  logic             w,
  input  logic             clr,
  output logic             busy
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam logic [AW-1:0]    REG0     = {AW{1'b0}};
  localparam logic [AW-1:0]    IDX_ONE  = AW'(1);
  localparam logic [AW-1:0]    LAST_IDX = AW'(DEPTH - 1);
  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};

  state_t           state_r;
  state_t           state_s;
  logic [AW-1:0]    idx_r;
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic             busy_s;
  logic             wr_en_s;

  assign busy_s  = (state_r == CLEAR);
  assign busy    = busy_s;
  // Writes to a hardwired register 0 are dropped here so they neither store nor forward.
  assign wr_en_s = w && !busy_s && !((ZERO_REG != 0) && (wn == REG0));

  function automatic logic [WIDTH-1:0] read_port(input logic [AW-1:0] rn);
    logic [WIDTH-1:0] val;
    if ((ZERO_REG != 0) && (rn == REG0)) begin
      val = ZERO_W;
    end else if ((BYPASS != 0) && wr_en_s && (rn == wn)) begin
      val = wd;
    end else begin
      val = mem_r[rn];
    end
    return val;
  endfunction

  // Combinational read ports with optional forwarding of the pending write.
  always_comb begin
    rd1 = read_port(rn1);
    rd2 = read_port(rn2);
  end

  // Next-state logic for the clear sweep; the sweep ends after the last index is written.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (clr) begin
          state_s = CLEAR;
        end else begin
          state_s = IDLE;
        end
      end
      CLEAR: begin
        if (idx_r == LAST_IDX) begin
          state_s = IDLE;
        end else begin
          state_s = CLEAR;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State, sweep index and storage update, with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      idx_r   <= REG0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= ZERO_W;
      end
    end else begin
      state_r <= state_s;
      if (busy_s) begin
        mem_r[idx_r] <= ZERO_W;
        if (idx_r == LAST_IDX) begin
          idx_r <= REG0;
        end else begin
          idx_r <= idx_r + IDX_ONE;
        end
      end else begin
        idx_r <= REG0;
        if (wr_en_s) begin
          mem_r[wn] <= wd;
        end
      end
    end
  end

endmodule

// File: tb/tb_rf_param.sv
// Self-checking bench for rf_param: default, no-forwarding and small (16x8, no zero register)
// instances driven by directed steps; expectations flow through a scoreboard queue.
module tb_rf_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [4:0]  rn1, rn2, wn;
  logic [31:0] wd;
  logic        w, clr;
  logic [31:0] d_rd1, d_rd2, n_rd1, n_rd2;
  logic        d_busy, n_busy;
  logic [2:0]  s_rn1, s_rn2, s_wn;
  logic [15:0] s_wd, s_rd1, s_rd2;
  logic        s_w, s_clr, s_busy;

  rf_param u_def (
    .clk(clk), .rst_n(rst_n), .rn1(rn1), .rn2(rn2), .rd1(d_rd1), .rd2(d_rd2),
    .wn(wn), .wd(wd), .w(w), .clr(clr), .busy(d_busy)
  );

  rf_param #(.BYPASS(0)) u_nb (
    .clk(clk), .rst_n(rst_n), .rn1(rn1), .rn2(rn2), .rd1(n_rd1), .rd2(n_rd2),
    .wn(wn), .wd(wd), .w(w), .clr(clr), .busy(n_busy)
  );

  rf_param #(.WIDTH(16), .DEPTH(8), .ZERO_REG(0)) u_small (
    .clk(clk), .rst_n(rst_n), .rn1(s_rn1), .rn2(s_rn2), .rd1(s_rd1), .rd2(s_rd2),
    .wn(s_wn), .wd(s_wd), .w(s_w), .clr(s_clr), .busy(s_busy)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [32];
  int          checks = 0;
  int          errors = 0;

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %h with nothing expected", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    @(negedge clk);
    w = 1'b1; wn = 5'(a); wd = d;
  endtask

  task automatic fill();
    for (int i = 0; i < 32; i++) begin
      wr(i, 32'(i * i));
      model[i] = (i == 0) ? 32'd0 : 32'(i * i);
    end
    @(negedge clk);
    w = 1'b0;
  endtask

  task automatic read_all();
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      rn1 = 5'(i); rn2 = 5'(31 - i);
      push("def_rd1_all", model[i]);
      push("def_rd2_all", model[31 - i]);
      push("nb_rd1_all", model[i]);
      #1;
      pop_check(d_rd1);
      pop_check(d_rd2);
      pop_check(n_rd1);
    end
  endtask

  task automatic check_busy(input logic exp, input string tag);
    push(tag, {31'd0, exp});
    push(tag, {31'd0, exp});
    #1;
    pop_check({31'd0, d_busy});
    pop_check({31'd0, n_busy});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; rn1 = 5'd0; rn2 = 5'd0; wn = 5'd0; wd = 32'd0; w = 1'b0; clr = 1'b0;
    s_rn1 = 3'd0; s_rn2 = 3'd0; s_wn = 3'd0; s_wd = 16'd0; s_w = 1'b0; s_clr = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 32'd0;

    // Reset state
    repeat (2) @(negedge clk);
    rst_n = 1'b1; rn1 = 5'd5; rn2 = 5'd31;
    push("rst_rd1", 32'd0); push("rst_rd2", 32'd0); push("rst_sbusy", 32'd0);
    #1;
    pop_check(d_rd1); pop_check(d_rd2); pop_check({31'd0, s_busy});
    check_busy(1'b0, "rst_busy");

    // Fill with i*i and read back
    fill();
    @(negedge clk);
    rn1 = 5'd5; rn2 = 5'd31;
    push("fill_rd1_r5", 32'd25); push("fill_rd2_r31", 32'd961);
    #1;
    pop_check(d_rd1); pop_check(d_rd2);
    @(negedge clk);
    rn1 = 5'd0;
    push("fill_rd1_r0", 32'd0);
    #1;
    pop_check(d_rd1);
    read_all();

    // Forwarding versus stored-only reads
    wr(7, 32'd3);
    @(negedge clk);
    w = 1'b1; wn = 5'd7; wd = 32'hDEAD; rn1 = 5'd7; rn2 = 5'd8;
    push("byp_def_rd1", 32'hDEAD); push("byp_nb_rd1", 32'd3); push("byp_def_rd2", 32'd64);
    #1;
    pop_check(d_rd1); pop_check(n_rd1); pop_check(d_rd2);
    @(negedge clk);
    w = 1'b0;
    push("after_def_rd1", 32'hDEAD); push("after_nb_rd1", 32'hDEAD);
    #1;
    pop_check(d_rd1); pop_check(n_rd1);
    model[7] = 32'hDEAD;

    // Register 0 stays zero even when written with forwarding enabled
    @(negedge clk);
    w = 1'b1; wn = 5'd0; wd = 32'h1234; rn1 = 5'd0;
    push("r0_byp_def", 32'd0); push("r0_byp_nb", 32'd0);
    #1;
    pop_check(d_rd1); pop_check(n_rd1);
    @(negedge clk);
    w = 1'b0;
    push("r0_after", 32'd0);
    #1;
    pop_check(d_rd1);

    // Clear sweep with ignored write and ignored clr mid-sweep
    @(negedge clk);
    clr = 1'b1;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      clr = 1'b0; w = 1'b0;
      if (k == 10) begin
        rn1 = 5'd3; rn2 = 5'd20; w = 1'b1; wn = 5'd9; wd = 32'd77;
        push("sweep_r3", 32'd0); push("sweep_r20", 32'd400);
        #1;
        pop_check(d_rd1); pop_check(d_rd2);
      end else if (k == 11) begin
        rn1 = 5'd9; w = 1'b1; wn = 5'd9; wd = 32'd77;
        push("sweep_nobyp_r9", 32'd0);
        #1;
        pop_check(d_rd1);
      end else if (k == 12) begin
        clr = 1'b1;
      end else begin
        w = 1'b0;
      end
      check_busy(1'b1, "sweep_busy");
    end
    @(negedge clk);
    w = 1'b0; clr = 1'b0;
    check_busy(1'b0, "sweep_done");
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    read_all();

    // Reset in the middle of a sweep overrides w and clr
    fill();
    @(negedge clk);
    clr = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      clr = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b0; w = 1'b1; wn = 5'd3; wd = 32'd55; clr = 1'b1;
    @(negedge clk);
    rst_n = 1'b1; w = 1'b0; clr = 1'b0;
    check_busy(1'b0, "midrst_busy");
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    read_all();

    // Write and clr together: write lands first, then a full sweep
    @(negedge clk);
    clr = 1'b1; w = 1'b1; wn = 5'd4; wd = 32'd99;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      clr = 1'b0; w = 1'b0; rn1 = 5'd4;
      if (k == 0) begin
        push("wclr_r4_k0", 32'd99);
        #1;
        pop_check(d_rd1);
      end else if (k == 5) begin
        push("wclr_r4_k5", 32'd0);
        #1;
        pop_check(d_rd1);
      end else begin
        rn2 = 5'd0;
      end
      check_busy(1'b1, "resweep_busy");
    end
    @(negedge clk);
    check_busy(1'b0, "resweep_done");

    // Small configuration without a zero register
    @(negedge clk);
    s_w = 1'b1; s_wn = 3'd0; s_wd = 16'hFFFF;
    @(negedge clk);
    s_wn = 3'd7; s_wd = 16'h1234;
    @(negedge clk);
    s_w = 1'b0; s_rn1 = 3'd0; s_rn2 = 3'd7;
    push("small_r0", 32'h0000FFFF); push("small_r7", 32'h00001234);
    #1;
    pop_check({16'd0, s_rd1}); pop_check({16'd0, s_rd2});
    @(negedge clk);
    s_clr = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      s_clr = 1'b0;
      push("small_busy", 32'd1);
      #1;
      pop_check({31'd0, s_busy});
    end
    @(negedge clk);
    push("small_done", 32'd0); push("small_r0_clr", 32'd0); push("small_r7_clr", 32'd0);
    #1;
    pop_check({31'd0, s_busy}); pop_check({16'd0, s_rd1}); pop_check({16'd0, s_rd2});

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: observed %0d entries expected 0", sb.size());
    end else begin
      checks++;
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_param.md
RF_PARAM -- requirements
Module: rf_param

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning data width in bits.
REQ-002 SHALL have parameter DEPTH, default 32, meaning number of registers, a power of two and at least 2.
REQ-003 SHALL have parameter AW, default $clog2(DEPTH), meaning register-number width.
REQ-004 SHALL have parameter ZERO_REG, default 1, meaning register 0 is hardwired to zero when set to 1.
REQ-005 SHALL have parameter BYPASS, default 1, meaning write-to-read forwarding is enabled when set to 1.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-008 SHALL have port rn1, input, AW bits: read port 1 register number.
REQ-009 SHALL have port rn2, input, AW bits: read port 2 register number.
REQ-010 SHALL have port rd1, output, WIDTH bits: read port 1 data.
REQ-011 SHALL have port rd2, output, WIDTH bits: read port 2 data.
REQ-012 SHALL have port wn, input, AW bits: write register number.
REQ-013 SHALL have port wd, input, WIDTH bits: write data.
REQ-014 SHALL have port w, input, 1 bit: write enable.
REQ-015 SHALL have port clr, input, 1 bit: single-cycle request to start a sequential clear of all registers.
REQ-016 SHALL have port busy, output, 1 bit: high while a clear sweep is in progress.

Function
REQ-017 Reads SHALL be combinational: rd1 = reg[rn1] and rd2 = reg[rn2], valid in the same cycle with no clock edge needed.
REQ-018 When w=1 and busy=0, reg[wn] SHALL take the value wd on the rising edge of clk.
REQ-019 With ZERO_REG=1, a read of register 0 SHALL return 0 and writes to register 0 SHALL be discarded.
REQ-020 With BYPASS=1, w=1, busy=0 and rnX==wn (and wn!=0 when ZERO_REG=1), rdX SHALL equal wd in the same cycle.
REQ-021 With BYPASS=0, reads SHALL return only stored values; new data SHALL be visible the cycle after the edge.
REQ-022 The FSM SHALL have exactly two states, IDLE and CLEAR; busy=1 if and only if the state is CLEAR.
REQ-023 In IDLE, clr=1 at an edge SHALL move the FSM to CLEAR and set the sweep index idx to 0.
REQ-024 In CLEAR, each edge SHALL write 0 to reg[idx] and increment idx; on the edge that writes reg[DEPTH-1], the FSM SHALL return to IDLE.
REQ-025 A clear sweep SHALL therefore hold busy high for exactly DEPTH cycles, starting the cycle after clr is sampled.
REQ-026 While busy=1, w SHALL be ignored: no register write and no bypass.
REQ-027 While busy=1, clr SHALL be ignored; a sweep is never restarted or extended.
REQ-028 Reads during CLEAR SHALL return current stored contents, i.e. 0 for indices below idx and old data otherwise.
REQ-029 If clr=1 and w=1 in the same IDLE cycle, the write SHALL complete on that edge and the sweep SHALL then start.
REQ-030 idx SHALL be AW bits wide and SHALL NOT wrap within a sweep.

Reset
REQ-031 On a rising edge with rst_n=0, all registers SHALL be set to 0, the FSM to IDLE, idx to 0 and busy to 0.
REQ-032 Reset SHALL override w and clr in the same cycle, including in the middle of a sweep; rd1 and rd2 SHALL read 0 after reset.

Verification
REQ-033 Defaults: write reg i = i*i for i = 0..31 one per cycle, then read -> rn1=5 gives rd1=25; rn2=31 gives rd2=961; rn1=0 gives 0.
REQ-034 Bypass: reg7 = 3; drive w=1, wn=7, wd=32'hDEAD, rn1=7 -> rd1=32'hDEAD before the edge; with BYPASS=0, rd1=3 before the edge and 32'hDEAD after.
REQ-035 Clear: fill with i*i, pulse clr -> busy high for 32 cycles; at cycle 10, reg3=0 and reg20=400; after the sweep, all regs read 0.
REQ-036 Write during busy: w=1, wn=9, wd=77 mid-sweep, sweep already past index 9 -> reg9 reads 0 after the sweep.
REQ-037 Reset mid-sweep: rst_n=0 at sweep cycle 5 -> next cycle busy=0 and all regs 0; a new clr starts a full 32-cycle sweep.
REQ-038 WIDTH=16, DEPTH=8, ZERO_REG=0: write reg0=16'hFFFF and reg7=16'h1234 -> both read back unchanged; a clr sweep lasts 8 cycles.
